// File: rtl/seqack_pkg.sv
// Shared toggle-handshake helpers: a transfer is pending while seq and ack differ,
// and both sides come out of reset with seq/ack low.
package seqack_pkg;

  localparam logic SEQACK_RST = 1'b0;

  function automatic logic seqack_pending(input logic seq, input logic ack);
    return seq ^ ack;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage with a synchronous write port and a combinational read port;
// isolated so a block-RAM flavour can be swapped in later.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; stale entries are never read because level gates every pop.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/seqack_fifo.sv
// Byte FIFO with toggle-handshake ports on both sides: DEPTH storage entries plus
// a registered output stage, with occupancy reported for LEDs and debug.
module seqack_fifo
  import seqack_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_seq,
  output logic             in_ack,
  output logic [WIDTH-1:0] out_data,
  output logic             out_seq,
  input  logic             out_ack,
  output logic [LW-1:0]    level,
  output logic             out_pending,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             r_in_ack;
  logic             r_out_seq;
  logic [WIDTH-1:0] r_out_data;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_rdata;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);

  // Push is judged on the current level only, so a same-edge pop never frees room for it.
  assign w_push = seqack_pending(in_seq, r_in_ack) && !w_full;
  assign w_pop  = !seqack_pending(r_out_seq, out_ack) && !w_empty;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push && !reset),
    .i_waddr (r_wptr),
    .i_wdata (in_data),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_in_ack   <= SEQACK_RST;
      r_out_seq  <= SEQACK_RST;
      r_out_data <= '0;
    end else begin
      if (w_push) begin
        r_wptr   <= r_wptr + 1'b1;
        r_in_ack <= ~r_in_ack;
      end
      if (w_pop) begin
        r_out_data <= w_rdata;
        r_rptr     <= r_rptr + 1'b1;
        r_out_seq  <= ~r_out_seq;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign in_ack      = r_in_ack;
  assign out_seq     = r_out_seq;
  assign out_data    = r_out_data;
  assign level       = r_level;
  assign full        = w_full;
  assign empty       = w_empty;
  assign out_pending = seqack_pending(r_out_seq, out_ack);

endmodule

// File: tb/tb_seqack_fifo.sv
// Scoreboard bench for seqack_fifo: offered bytes are queued as expectations and a
// monitor compares each new byte the FIFO presents; occupancy is checked against counts.
module tb_seqack_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_seq = 1'b0;
  logic             in_ack;
  logic [WIDTH-1:0] out_data;
  logic             out_seq;
  logic             out_ack = 1'b0;
  logic [LW-1:0]    level;
  logic             out_pending;
  logic             full;
  logic             empty;

  seqack_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_seq      (in_seq),
    .in_ack      (in_ack),
    .out_data    (out_data),
    .out_seq     (out_seq),
    .out_ack     (out_ack),
    .level       (level),
    .out_pending (out_pending),
    .full        (full),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic             mon_seq = 1'b0;
  int               n_loaded = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Monitor: every toggle of out_seq is a new byte, compared with the oldest expectation.
  always begin
    @(posedge clk);
    #1;
    if (!reset && out_seq !== mon_seq) begin
      mon_seq = out_seq;
      n_loaded++;
      if (exp_q.size() == 0) timeout("unexpected_output");
      else check("out_data_order", out_data, exp_q.pop_front());
    end
  end

  task automatic offer(input logic [WIDTH-1:0] d);
    in_data = d;
    in_seq  = ~in_seq;
    exp_q.push_back(d);
  endtask

  task automatic wait_acked(input string name);
    int n = 0;
    while (in_ack !== in_seq && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ack !== in_seq) timeout(name);
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    offer(d);
    wait_acked("push_ack");
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_pending || !empty) && n < 300) begin
      if (out_pending) out_ack = out_seq;
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || out_pending || !empty) timeout("drain");
  endtask

  // One reset edge; the neighbours drop their own seq/ack on the same reset.
  task automatic do_reset();
    reset   = 1'b1;
    in_seq  = 1'b0;
    out_ack = 1'b0;
    @(negedge clk);
    check("rst_level", level, 0);
    check("rst_in_ack", in_ack, 0);
    check("rst_out_seq", out_seq, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_pending", out_pending, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    exp_q.delete();
    mon_seq = 1'b0;
    reset   = 1'b0;
  endtask

  initial begin
    int lvl_min, lvl_max, sent, n, n_acked;
    logic outstanding;
    logic [LW-1:0] held_level;
    logic held_ack;

    @(negedge clk);
    do_reset();

    // Single push: ack after one edge, output after the second.
    offer(8'hA5);
    @(negedge clk);
    check("t1_in_ack", in_ack, 1);
    check("t1_level_e1", level, 1);
    check("t1_no_bypass", out_seq, 0);
    @(negedge clk);
    check("t1_out_seq", out_seq, 1);
    check("t1_out_data", out_data, 8'hA5);
    check("t1_level_e2", level, 0);
    out_ack = 1'b1;
    @(negedge clk);
    check("t1_out_pending", out_pending, 0);
    check("t1_empty", empty, 1);

    // Consumer stalled: 17 bytes fill output register plus all storage.
    for (int i = 0; i <= 16; i++) push(WIDTH'(i));
    @(negedge clk);
    check("t2_level_full", level, DEPTH);
    check("t2_full", full, 1);
    check("t2_out_pending", out_pending, 1);
    offer(8'h11);
    repeat (3) @(negedge clk);
    check("t2_18th_not_acked", in_ack != in_seq, 1);
    check("t2_level_hold", level, DEPTH);
    // Pop coincides with the blocked push: refused on that edge, taken on the next.
    out_ack = out_seq;
    @(negedge clk);
    check("t4_level_pop", level, DEPTH - 1);
    check("t4_push_refused", in_ack != in_seq, 1);
    @(negedge clk);
    check("t4_level_refill", level, DEPTH);
    check("t4_push_taken", in_ack, in_seq);
    drain();

    // Both neighbours respond every clock: 40 bytes, level constant in the middle.
    lvl_min = 99;
    lvl_max = -1;
    sent = 0;
    n = 0;
    while ((sent < 40 || exp_q.size() != 0 || out_pending) && n < 200) begin
      if (sent >= 2 && sent < 40) begin
        if (int'(level) < lvl_min) lvl_min = int'(level);
        if (int'(level) > lvl_max) lvl_max = int'(level);
      end
      if (in_ack === in_seq && sent < 40) begin
        offer(WIDTH'(8'h40 + sent));
        sent++;
      end
      if (out_pending) out_ack = out_seq;
      @(negedge clk);
      n++;
    end
    if (sent < 40 || exp_q.size() != 0) timeout("t3_stream");
    check("t3_level_min", lvl_min, 1);
    check("t3_level_max", lvl_max, 1);
    check("t3_cycles", n < 50, 1);

    // Hold: in_seq == in_ack with wiggling in_data must not push.
    for (int i = 0; i < 3; i++) push(WIDTH'(8'hC0 + i));
    @(negedge clk);
    held_level = level;
    held_ack   = in_ack;
    check("t6_level_before", held_level, 2);
    for (int i = 0; i < 8; i++) begin
      in_data = WIDTH'($urandom);
      @(negedge clk);
    end
    check("t6_level_held", level, held_level);
    check("t6_in_ack_held", in_ack, held_ack);
    drain();

    // Reset with level=5 and a pending output.
    for (int i = 0; i < 6; i++) push(WIDTH'(8'h90 + i));
    @(negedge clk);
    check("t5_level5", level, 5);
    check("t5_pending", out_pending, 1);
    do_reset();
    push(8'h3C);
    drain();

    // Random stimulus with random stalls on both sides.
    n_acked = 0;
    n_loaded = 0;
    outstanding = 1'b0;
    sent = 0;
    n = 0;
    while ((sent < 200 || outstanding || exp_q.size() != 0 || out_pending) && n < 5000) begin
      if (outstanding && in_ack === in_seq) begin
        n_acked++;
        outstanding = 1'b0;
      end
      if (n % 8 == 0) begin
        check("rnd_level", level, n_acked - n_loaded);
        check("rnd_full", full, (n_acked - n_loaded) == DEPTH);
      end
      if (!outstanding && sent < 200 && $urandom_range(9) < 7) begin
        offer(WIDTH'($urandom));
        outstanding = 1'b1;
        sent++;
      end else if (!outstanding) begin
        in_data = WIDTH'($urandom);
      end
      if (out_pending && $urandom_range(9) < 5) out_ack = out_seq;
      @(negedge clk);
      n++;
    end
    if (n >= 5000) timeout("rnd_stream");
    check("rnd_count", n_loaded, 200);
    check("rnd_empty_end", empty, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
